// File: rtl/mst_arbiter.sv
// Three-master arbiter for a single shared slave port.
// Masters: m0 = core data port, m1 = jtag, m2 = debug/DMA.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   mN_req_i/we_i/addr_i/data_i  master request, write flag, address, write data
//   mN_data_o/ack_o          read data (held until next completion), 1-cycle ack
//   s_req_o/we_o/addr_o/data_o   shared slave request, stable for the whole BUSY period
//   s_data_i/s_ack_i         slave read data and acknowledge
//   grant_o                  one-hot owner of the slave, zero when idle
//   hold_flag_o              core pipeline hold (m0 request not yet acked)
//   timeout_o                1-cycle pulse when a transfer is force-terminated
// TIMEOUT_CYCLES must be at least 1.
module mst_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          RR_EN          = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,

    input  logic        m2_req_i,
    input  logic        m2_we_i,
    input  logic [31:0] m2_addr_i,
    input  logic [31:0] m2_data_i,
    output logic [31:0] m2_data_o,
    output logic        m2_ack_o,

    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,

    output logic [2:0]  grant_o,
    output logic        hold_flag_o,
    output logic        timeout_o
);

    localparam int unsigned NM    = 3;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    logic [1:0]        last_grant;
    logic [1:0]        gidx;
    logic [CNT_W-1:0]  cnt;
    logic [NM-1:0]     ack_q;
    logic [DW-1:0]     rdata_q [NM];

    logic [NM-1:0]     req;
    logic [NM-1:0]     we_in;
    logic [AW-1:0]     addr_in [NM];
    logic [DW-1:0]     wdata_in [NM];

    logic [1:0]        win_idx_c;
    logic              win_vld_c;
    logic [1:0]        rr0_c, rr1_c, rr2_c;
    logic              done_c;

    assign req         = {m2_req_i, m1_req_i, m0_req_i};
    assign we_in       = {m2_we_i, m1_we_i, m0_we_i};
    assign addr_in[0]  = m0_addr_i;
    assign addr_in[1]  = m1_addr_i;
    assign addr_in[2]  = m2_addr_i;
    assign wdata_in[0] = m0_data_i;
    assign wdata_in[1] = m1_data_i;
    assign wdata_in[2] = m2_data_i;

    // Successor of a master index in round-robin order (0 -> 1 -> 2 -> 0).
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Winner selection: round-robin starting after last_grant, or fixed m2 > m1 > m0.
    always_comb begin
        win_idx_c = 2'd0;
        win_vld_c = |req;
        rr0_c     = rr_next(last_grant);
        rr1_c     = rr_next(rr0_c);
        rr2_c     = rr_next(rr1_c);
        if (RR_EN) begin
            if (req[rr0_c])      win_idx_c = rr0_c;
            else if (req[rr1_c]) win_idx_c = rr1_c;
            else                 win_idx_c = rr2_c;
        end else begin
            if (req[2])          win_idx_c = 2'd2;
            else if (req[1])     win_idx_c = 2'd1;
            else                 win_idx_c = 2'd0;
        end
    end

    // A BUSY cycle ends the transfer on slave ack or on the last allowed cycle.
    assign done_c = s_ack_i || (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 2'd2;
            gidx       <= 2'd0;
            cnt        <= '0;
            ack_q      <= '0;
            grant_o    <= '0;
            s_req_o    <= 1'b0;
            s_we_o     <= 1'b0;
            s_addr_o   <= '0;
            s_data_o   <= '0;
            timeout_o  <= 1'b0;
            for (int i = 0; i < NM; i++) rdata_q[i] <= '0;
        end else begin
            ack_q     <= '0;
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld_c) begin
                        state    <= BUSY;
                        gidx     <= win_idx_c;
                        grant_o  <= 3'b001 << win_idx_c;
                        s_req_o  <= 1'b1;
                        s_we_o   <= we_in[win_idx_c];
                        s_addr_o <= addr_in[win_idx_c];
                        s_data_o <= wdata_in[win_idx_c];
                        cnt      <= '0;
                    end
                end
                BUSY: begin
                    if (done_c) begin
                        state         <= IDLE;
                        s_req_o       <= 1'b0;
                        grant_o       <= '0;
                        last_grant    <= gidx;
                        ack_q[gidx]   <= 1'b1;
                        // Ack takes precedence over a timeout landing in the same cycle.
                        rdata_q[gidx] <= s_ack_i ? s_data_i : '0;
                        timeout_o     <= ~s_ack_i;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m0_ack_o  = ack_q[0];
    assign m1_ack_o  = ack_q[1];
    assign m2_ack_o  = ack_q[2];
    assign m0_data_o = rdata_q[0];
    assign m1_data_o = rdata_q[1];
    assign m2_data_o = rdata_q[2];

    // Stall the core while its data request is outstanding.
    assign hold_flag_o = m0_req_i & ~m0_ack_o;

endmodule

// File: tb/tb_mst_arbiter.sv
// Scoreboard bench for mst_arbiter: three instances (default, fixed priority,
// TIMEOUT_CYCLES=4) share stimulus; sel picks the instance being observed.
module tb_mst_arbiter;

    typedef struct packed {
        logic [2:0]  ack;
        logic [31:0] rd2;
        logic [31:0] rd1;
        logic [31:0] rd0;
        logic        s_req;
        logic        s_we;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        logic [2:0]  grant;
        logic        hold;
        logic        tmo;
    } obs_t;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] data;
        logic        tmo;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [2:0]  m_req;
    logic [2:0]  m_we;
    logic [31:0] m_addr  [3];
    logic [31:0] m_wdata [3];
    logic [31:0] s_rdata;
    logic        s_ack;
    logic [1:0]  sel;

    obs_t        obs_all [3];
    obs_t        o;
    exp_t        exp_q [$];

    int          checks;
    int          failures;
    int          tmo_cnt;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] d0, d1, d2, sa, sd;
        logic        a0, a1, a2, sr, sw, hf, to;
        logic [2:0]  gr;

        mst_arbiter #(
            .TIMEOUT_CYCLES((g == 2) ? 4 : 255),
            .RR_EN((g == 1) ? 1'b0 : 1'b1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .m0_req_i   (m_req[0]),
            .m0_we_i    (m_we[0]),
            .m0_addr_i  (m_addr[0]),
            .m0_data_i  (m_wdata[0]),
            .m0_data_o  (d0),
            .m0_ack_o   (a0),
            .m1_req_i   (m_req[1]),
            .m1_we_i    (m_we[1]),
            .m1_addr_i  (m_addr[1]),
            .m1_data_i  (m_wdata[1]),
            .m1_data_o  (d1),
            .m1_ack_o   (a1),
            .m2_req_i   (m_req[2]),
            .m2_we_i    (m_we[2]),
            .m2_addr_i  (m_addr[2]),
            .m2_data_i  (m_wdata[2]),
            .m2_data_o  (d2),
            .m2_ack_o   (a2),
            .s_req_o    (sr),
            .s_we_o     (sw),
            .s_addr_o   (sa),
            .s_data_o   (sd),
            .s_data_i   (s_rdata),
            .s_ack_i    (s_ack),
            .grant_o    (gr),
            .hold_flag_o(hf),
            .timeout_o  (to)
        );

        assign obs_all[g] = {{a2, a1, a0}, d2, d1, d0, sr, sw, sa, sd, gr, hf, to};
    end

    assign o = obs_all[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] idx, input logic [31:0] data, input logic tmo);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        e.tmo  = tmo;
        exp_q.push_back(e);
    endtask

    task automatic reset_all();
        rst     = 1'b1;
        m_req   = '0;
        m_we    = '0;
        s_ack   = 1'b0;
        s_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            m_addr[i]  = '0;
            m_wdata[i] = '0;
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Monitor: every ack presented by the observed DUT is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t        e;
        logic [1:0]  aidx;
        logic [31:0] rdv;
        if (!rst && (o.ack != 3'b000)) begin
            chk("ack_onehot", 32'($onehot(o.ack)), 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 32'(o.ack), 32'd0);
            end else begin
                e    = exp_q.pop_front();
                aidx = o.ack[2] ? 2'd2 : (o.ack[1] ? 2'd1 : 2'd0);
                rdv  = (aidx == 2'd2) ? o.rd2 : ((aidx == 2'd1) ? o.rd1 : o.rd0);
                chk("ack_master", 32'(aidx), 32'(e.idx));
                chk("ack_data", rdv, e.data);
                chk("ack_timeout_flag", 32'(o.tmo), 32'(e.tmo));
            end
        end
        if (!rst && o.tmo) begin
            tmo_cnt++;
            if (o.ack == 3'b000) chk("timeout_without_ack", 32'(o.tmo), 32'd0);
        end
    end

    initial begin
        int n;
        logic [1:0] order [4];

        checks   = 0;
        failures = 0;
        tmo_cnt  = 0;
        sel      = 2'd0;
        rst      = 1'b1;

        // Single read on m0, slave acks 3 cycles after s_req_o.
        reset_all();
        chk("rst_grant", 32'(o.grant), 32'd0);
        chk("rst_s_req", 32'(o.s_req), 32'd0);
        chk("rst_s_we", 32'(o.s_we), 32'd0);
        chk("rst_s_addr", o.s_addr, 32'd0);
        chk("rst_s_data", o.s_wdata, 32'd0);
        chk("rst_acks", 32'(o.ack), 32'd0);
        chk("rst_timeout", 32'(o.tmo), 32'd0);
        m_req[0]  = 1'b1;
        m_we[0]   = 1'b0;
        m_addr[0] = 32'h0000_1000;
        push(2'd0, 32'hDEAD_BEEF, 1'b0);
        #1;
        chk("read_hold_T", 32'(o.hold), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("read_s_req", 32'(o.s_req), 32'd1);
            chk("read_s_addr", o.s_addr, 32'h0000_1000);
            chk("read_s_we", 32'(o.s_we), 32'd0);
            chk("read_grant", 32'(o.grant), 32'd1);
            chk("read_hold", 32'(o.hold), 32'd1);
            if (k == 4) begin
                s_ack   = 1'b1;
                s_rdata = 32'hDEAD_BEEF;
            end
        end
        tick();
        s_ack    = 1'b0;
        m_req[0] = 1'b0;
        chk("read_ack_cycle_ack", 32'(o.ack), 32'd1);
        chk("read_ack_cycle_s_req", 32'(o.s_req), 32'd0);
        chk("read_ack_cycle_grant", 32'(o.grant), 32'd0);
        tick();
        chk("read_ack_single_pulse", 32'(o.ack), 32'd0);
        chk("read_data_held", o.rd0, 32'hDEAD_BEEF);

        // Round-robin contention with a 1-cycle-ack slave.
        reset_all();
        order = '{2'd0, 2'd1, 2'd2, 2'd0};
        for (int k = 0; k < 4; k++) push(order[k], 32'h1111_0000 + 32'(k), 1'b0);
        m_req = 3'b111;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            s_ack = 1'b0;
            if (o.s_req) begin
                chk("rr_grant", 32'(o.grant), 32'(3'b001 << order[n]));
                s_ack   = 1'b1;
                s_rdata = 32'h1111_0000 + 32'(n);
                n++;
            end
        end
        tick();
        s_ack = 1'b0;
        m_req = '0;
        chk("rr_transfers_done", 32'(n), 32'd4);
        tick();
        tick();

        // Reset mid-transfer on an m1 write; the late slave ack must be ignored.
        reset_all();
        m_req[1]   = 1'b1;
        m_we[1]    = 1'b1;
        m_addr[1]  = 32'h0000_4000;
        m_wdata[1] = 32'h0000_0077;
        tick();
        chk("abort_s_req", 32'(o.s_req), 32'd1);
        chk("abort_grant", 32'(o.grant), 32'd2);
        chk("abort_s_we", 32'(o.s_we), 32'd1);
        m_req[1] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        s_ack   = 1'b1;
        s_rdata = 32'h0000_0099;
        chk("abort_s_req_after_rst", 32'(o.s_req), 32'd0);
        chk("abort_grant_after_rst", 32'(o.grant), 32'd0);
        chk("abort_rd0_cleared", o.rd0, 32'd0);
        chk("abort_rd1_cleared", o.rd1, 32'd0);
        tick();
        s_ack = 1'b0;
        chk("abort_late_ack_ignored", 32'(o.ack), 32'd0);
        chk("abort_stays_idle", 32'(o.s_req), 32'd0);
        tick();
        chk("abort_no_ack", 32'(o.ack), 32'd0);

        // m2 write; master inputs change while BUSY, slave side must not.
        reset_all();
        m_req[2]   = 1'b1;
        m_we[2]    = 1'b1;
        m_addr[2]  = 32'h0000_2000;
        m_wdata[2] = 32'h0000_0055;
        push(2'd2, 32'h1234_5678, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 1) begin
                m_addr[2]  = 32'hFFFF_0000;
                m_wdata[2] = 32'h0000_00AA;
                m_we[2]    = 1'b0;
            end
            chk("wr_s_req", 32'(o.s_req), 32'd1);
            chk("wr_s_addr", o.s_addr, 32'h0000_2000);
            chk("wr_s_data", o.s_wdata, 32'h0000_0055);
            chk("wr_s_we", 32'(o.s_we), 32'd1);
            chk("wr_grant", 32'(o.grant), 32'd4);
            if (k == 3) begin
                s_ack   = 1'b1;
                s_rdata = 32'h1234_5678;
            end
        end
        tick();
        s_ack    = 1'b0;
        m_req[2] = 1'b0;
        chk("wr_ack", 32'(o.ack), 32'd4);
        tick();
        chk("wr_ack_single_pulse", 32'(o.ack), 32'd0);
        chk("wr_idle", 32'(o.s_req), 32'd0);

        // Fixed priority: m0 and m2 together, m2 first.
        sel = 2'd1;
        reset_all();
        m_req     = 3'b101;
        m_addr[0] = 32'h0000_0010;
        m_addr[2] = 32'h0000_0020;
        push(2'd2, 32'hB000_0002, 1'b0);
        push(2'd0, 32'hB000_0000, 1'b0);
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            tick();
            chk("fp_hold", 32'(o.hold), 32'd1);
            s_ack = 1'b0;
            if (o.ack[2]) m_req[2] = 1'b0;
            if (o.s_req) begin
                chk("fp_grant", 32'(o.grant), (n == 0) ? 32'd4 : 32'd1);
                s_ack   = 1'b1;
                s_rdata = (n == 0) ? 32'hB000_0002 : 32'hB000_0000;
                n++;
            end
        end
        tick();
        s_ack = 1'b0;
        m_req = '0;
        chk("fp_transfers_done", 32'(n), 32'd2);
        tick();

        // Timeout after 4 BUSY cycles, preceded by a normal m1 read.
        sel = 2'd2;
        reset_all();
        m_req[1]  = 1'b1;
        m_addr[1] = 32'h0000_3000;
        push(2'd1, 32'hCAFE_0001, 1'b0);
        tick();
        chk("to_pre_grant", 32'(o.grant), 32'd2);
        s_ack    = 1'b1;
        s_rdata  = 32'hCAFE_0001;
        m_req[1] = 1'b0;
        tick();
        s_ack = 1'b0;
        chk("to_pre_ack", 32'(o.ack), 32'd2);
        tick();
        tmo_cnt   = 0;
        m_req[1]  = 1'b1;
        m_addr[1] = 32'h0000_3004;
        push(2'd1, 32'h0000_0000, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) m_req[1] = 1'b0;
            chk("to_busy_s_req", 32'(o.s_req), 32'd1);
            chk("to_busy_no_pulse", 32'(o.tmo), 32'd0);
        end
        tick();
        chk("to_pulse", 32'(o.tmo), 32'd1);
        chk("to_ack", 32'(o.ack), 32'd2);
        chk("to_s_req", 32'(o.s_req), 32'd0);
        chk("to_grant", 32'(o.grant), 32'd0);
        tick();
        chk("to_pulse_end", 32'(o.tmo), 32'd0);
        chk("to_pulse_count", 32'(tmo_cnt), 32'd1);
        chk("to_rd1_zero", o.rd1, 32'd0);
        tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
